// File: rtl/i2c_mem_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : i2c_mem_slave                                                   |
// | Purpose  : Oversampled I2C slave fronting a 128 x 8 byte memory; records   |
// |            the address, byte and direction of the last completed access.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module i2c_mem_slave #(
  parameter int FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic [6:0] last_addr,
  output logic [7:0] last_data,
  output logic       last_op
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ADDR      = 3'd1;
  localparam logic [2:0] S_ADDR_ACK  = 3'd2;
  localparam logic [2:0] S_WR_DATA   = 3'd3;
  localparam logic [2:0] S_WR_ACK    = 3'd4;
  localparam logic [2:0] S_RD_DATA   = 3'd5;
  localparam logic [2:0] S_RD_ACK    = 3'd6;
  localparam logic [2:0] S_WAIT_STOP = 3'd7;

  localparam logic [2:0] c_filt_max = 3'(FILT_LEN - 1);

  logic [1:0] w_raw;
  logic [1:0] w_filt;
  logic       w_scl, w_sda;
  logic       r_scl_d, r_sda_d;
  logic       w_scl_rise, w_scl_fall, w_start, w_stop;

  logic [2:0] r_state, w_state_nxt;
  logic [2:0] r_bitcnt;
  logic [7:0] r_shift;
  logic [7:0] r_byte;
  logic [6:0] r_addr;
  logic       r_op;
  logic       r_ack_drv;
  logic       r_wr_pend;
  logic       r_sda_oe, w_oe_nxt;
  logic       r_done;
  logic [6:0] r_last_addr;
  logic [7:0] r_last_data;
  logic       r_last_op;
  logic [7:0] r_mem [128];
  logic [7:0] w_rd_byte;

  assign w_raw = {sda_in, scl};

  // Index 0 is scl, index 1 is sda; the filtered level only moves after FILT_LEN agreeing samples.
  for (genvar g = 0; g < 2; g++) begin : g_filt
    logic       r_s1, r_s2, r_f;
    logic [2:0] r_cnt;
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_s1  <= 1'b1;
        r_s2  <= 1'b1;
        r_f   <= 1'b1;
        r_cnt <= '0;
      end else begin
        r_s1 <= w_raw[g];
        r_s2 <= r_s1;
        if (r_s2 == r_f) begin
          r_cnt <= '0;
        end else if (r_cnt == c_filt_max) begin
          r_f   <= r_s2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 3'd1;
        end
      end
    end
    assign w_filt[g] = r_f;
  end

  assign w_scl      = w_filt[0];
  assign w_sda      = w_filt[1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = r_sda_d & ~w_sda & w_scl & r_scl_d;
  assign w_stop     = ~r_sda_d & w_sda & w_scl & r_scl_d;
  assign w_rd_byte  = r_mem[r_addr];

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_stop) begin
      w_state_nxt = S_IDLE;
    end else if (w_start) begin
      w_state_nxt = S_ADDR;
    end else begin
      case (r_state)
        S_ADDR:     if (w_scl_rise && r_bitcnt == 3'd7) w_state_nxt = S_ADDR_ACK;
        S_ADDR_ACK: if (w_scl_fall && r_ack_drv) w_state_nxt = r_op ? S_RD_DATA : S_WR_DATA;
        S_WR_DATA:  if (w_scl_rise && r_bitcnt == 3'd7) w_state_nxt = S_WR_ACK;
        S_WR_ACK:   if (w_scl_fall && r_ack_drv) w_state_nxt = S_WAIT_STOP;
        S_RD_DATA:  if (w_scl_fall && r_bitcnt == 3'd7) w_state_nxt = S_RD_ACK;
        S_RD_ACK:   if (w_scl_rise) w_state_nxt = S_WAIT_STOP;
        default:    ;
      endcase
    end
  end

  // ACK slots span falling edge to falling edge; the read MSB goes out on the edge that closes ADDR_ACK.
  always_comb begin
    busy     = (r_state != S_IDLE);
    w_oe_nxt = r_sda_oe;
    if (w_stop || w_start) begin
      w_oe_nxt = 1'b0;
    end else begin
      case (r_state)
        S_ADDR_ACK: if (w_scl_fall) w_oe_nxt = r_ack_drv ? (r_op & ~w_rd_byte[7]) : 1'b1;
        S_WR_ACK:   if (w_scl_fall) w_oe_nxt = ~r_ack_drv;
        S_RD_DATA:  if (w_scl_fall) w_oe_nxt = (r_bitcnt == 3'd7) ? 1'b0 : ~r_shift[6];
        default:    w_oe_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_scl_d     <= 1'b1;
      r_sda_d     <= 1'b1;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_byte      <= '0;
      r_addr      <= '0;
      r_op        <= 1'b0;
      r_ack_drv   <= 1'b0;
      r_wr_pend   <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_done      <= 1'b0;
      r_last_addr <= '0;
      r_last_data <= '0;
      r_last_op   <= 1'b0;
      for (int i = 0; i < 128; i++) r_mem[i] <= '0;
    end else begin
      r_scl_d  <= w_scl;
      r_sda_d  <= w_sda;
      r_sda_oe <= w_oe_nxt;
      r_done   <= 1'b0;
      if (r_wr_pend) begin
        r_mem[r_addr] <= r_byte;
        r_wr_pend     <= 1'b0;
      end
      if (w_stop) begin
        r_ack_drv <= 1'b0;
        if (r_state == S_WAIT_STOP) begin
          r_done      <= 1'b1;
          r_last_addr <= r_addr;
          r_last_data <= r_byte;
          r_last_op   <= r_op;
        end
      end else if (w_start) begin
        r_bitcnt  <= '0;
        r_ack_drv <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR: if (w_scl_rise) begin
            r_shift  <= {r_shift[6:0], w_sda};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_addr <= r_shift[6:0];
              r_op   <= w_sda;
            end
          end
          S_ADDR_ACK, S_WR_ACK: if (w_scl_fall) begin
            r_ack_drv <= ~r_ack_drv;
            r_bitcnt  <= '0;
            if (r_ack_drv && r_state == S_ADDR_ACK && r_op) begin
              r_shift <= w_rd_byte;
              r_byte  <= w_rd_byte;
            end
          end
          S_WR_DATA: if (w_scl_rise) begin
            r_shift  <= {r_shift[6:0], w_sda};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_byte    <= {r_shift[6:0], w_sda};
              r_wr_pend <= 1'b1;
            end
          end
          S_RD_DATA: if (w_scl_fall) begin
            r_shift  <= {r_shift[6:0], 1'b0};
            r_bitcnt <= r_bitcnt + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe    = r_sda_oe;
  assign done      = r_done;
  assign last_addr = r_last_addr;
  assign last_data = r_last_data;
  assign last_op   = r_last_op;

endmodule
`default_nettype wire

// File: tb/tb_i2c_mem_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_i2c_mem_slave                                                |
// | Purpose  : Directed I2C master bench for i2c_mem_slave.                    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_i2c_mem_slave;

  localparam int c_q = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, busy, done, last_op;
  logic [6:0] last_addr;
  logic [7:0] last_data;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  assign sda_line = sda_m & ~sda_oe;

  i2c_mem_slave #(.FILT_LEN(3)) u_dut (
    .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_line), .sda_oe(sda_oe),
    .busy(busy), .done(done), .last_addr(last_addr), .last_data(last_data), .last_op(last_op)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(c_q);
    scl   = 1'b1; tick(c_q);
    sda_m = 1'b0; tick(c_q);
    scl   = 1'b0; tick(c_q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(c_q);
    scl   = 1'b1; tick(c_q);
    sda_m = 1'b1; tick(c_q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    tick(c_q);
    scl   = 1'b1; tick(2 * c_q);
    scl   = 1'b0; tick(c_q);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; tick(c_q);
    scl   = 1'b1; tick(c_q);
    b     = sda_line; tick(c_q);
    scl   = 1'b0; tick(c_q);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic recv_byte(output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      v[i] = b;
    end
  endtask

  task automatic write_txn(input logic [6:0] a, input logic [7:0] d, output logic ack1, output logic ack2);
    i2c_start();
    send_byte({a, 1'b0});
    recv_bit(ack1);
    send_byte(d);
    recv_bit(ack2);
    i2c_stop();
  endtask

  task automatic read_txn(input logic [6:0] a, input logic nack, output logic ack1, output logic [7:0] d);
    i2c_start();
    send_byte({a, 1'b1});
    recv_bit(ack1);
    recv_byte(d);
    send_bit(nack);
    i2c_stop();
  endtask

  logic       a1, a2;
  logic [7:0] rd;
  int         d0;

  initial begin
    rst = 1'b0; tick(5);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_last_addr", last_addr, 0);
    chk("rst_last_data", last_data, 0);
    chk("rst_last_op", last_op, 0);
    rst = 1'b1; tick(5);

    // read of an untouched address after reset
    d0 = done_cnt;
    read_txn(7'd4, 1'b0, a1, rd);
    chk("rd4_ack", a1, 0);
    chk("rd4_data", rd, 8'h00);
    chk("rd4_done", done_cnt - d0, 1);
    chk("rd4_last_addr", last_addr, 4);
    chk("rd4_last_op", last_op, 1);

    d0 = done_cnt;
    write_txn(7'd3, 8'h05, a1, a2);
    chk("wr3_ack_addr", a1, 0);
    chk("wr3_ack_data", a2, 0);
    chk("wr3_done", done_cnt - d0, 1);
    chk("wr3_last_addr", last_addr, 3);
    chk("wr3_last_data", last_data, 8'h05);
    chk("wr3_last_op", last_op, 0);
    chk("wr3_busy", busy, 0);

    d0 = done_cnt;
    write_txn(7'd2, 8'hA5, a1, a2);
    read_txn(7'd2, 1'b1, a1, rd);
    chk("rd2_data", rd, 8'hA5);
    chk("rd2_last_data", last_data, 8'hA5);
    chk("rd2_last_op", last_op, 1);
    chk("rd2_done", done_cnt - d0, 2);

    // STOP after four data bits aborts the write
    d0 = done_cnt;
    i2c_start();
    send_byte({7'd1, 1'b0});
    recv_bit(a1);
    repeat (4) send_bit(1'b1);
    i2c_stop();
    chk("abort_done", done_cnt - d0, 0);
    chk("abort_busy", busy, 0);
    chk("abort_last_addr", last_addr, 2);
    read_txn(7'd1, 1'b0, a1, rd);
    chk("abort_mem1", rd, 8'h00);

    // repeated START in the middle of a write
    d0 = done_cnt;
    i2c_start();
    send_byte({7'd1, 1'b0});
    recv_bit(a1);
    repeat (3) send_bit(1'b1);
    write_txn(7'd1, 8'h03, a1, a2);
    chk("rs_done", done_cnt - d0, 1);
    chk("rs_last_data", last_data, 8'h03);
    read_txn(7'd1, 1'b0, a1, rd);
    chk("rs_mem1", rd, 8'h03);

    // short SDA glitches with SCL high are not bus conditions
    d0 = done_cnt;
    sda_m = 1'b0; tick(2);
    sda_m = 1'b1; tick(3 * c_q);
    chk("glitch_idle_busy", busy, 0);
    i2c_start();
    chk("glitch_start_busy", busy, 1);
    scl   = 1'b1; tick(c_q);
    sda_m = 1'b1; tick(2);
    sda_m = 1'b0; tick(3 * c_q);
    chk("glitch_txn_busy", busy, 1);
    scl   = 1'b0; tick(c_q);
    i2c_stop();
    chk("glitch_stop_busy", busy, 0);
    chk("glitch_done", done_cnt - d0, 0);

    // reset while the slave drives the address ACK
    i2c_start();
    send_byte({7'd5, 1'b0});
    chk("mid_ack_drive", sda_oe, 1);
    sda_m = 1'b1;
    rst   = 1'b0; tick(1);
    chk("mid_rst_sda_oe", sda_oe, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_last_data", last_data, 0);
    rst = 1'b1; tick(c_q);
    scl = 1'b1; tick(3 * c_q);
    chk("post_rst_busy", busy, 0);
    read_txn(7'd2, 1'b0, a1, rd);
    chk("post_rst_mem2", rd, 8'h00);
    chk("post_rst_ack", a1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
